// File: rtl/lh_pkg.sv
// Shared constants, status codes and FSM encoding for the light_hash
// requester arbiter.
package lh_pkg;

  localparam logic [7:0] HEAD_BYTE = 8'hFF;
  localparam logic [7:0] TAIL_BYTE = 8'h00;

  localparam logic [7:0] LO_MIN = 8'h20;
  localparam logic [7:0] LO_MAX = 8'h7E;
  localparam logic [7:0] HI_MIN = 8'hA1;
  localparam logic [7:0] HI_MAX = 8'hFE;

  typedef enum logic [1:0] {
    STAT_OK           = 2'd0,
    STAT_INVALID_BYTE = 2'd1,
    STAT_TOO_LONG     = 2'd2,
    STAT_TIMEOUT      = 2'd3
  } lh_status_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HEAD  = 3'd1,
    S_DATA  = 3'd2,
    S_TAIL  = 3'd3,
    S_WAIT  = 3'd4,
    S_FLUSH = 3'd5,
    S_RESP  = 3'd6
  } lh_arb_state_t;

  // Framing bytes 0x00/0xFF are never legal payload.
  function automatic logic is_payload_byte(input logic [7:0] b);
    return ((b >= LO_MIN) && (b <= LO_MAX)) || ((b >= HI_MIN) && (b <= HI_MAX));
  endfunction

endpackage

// File: rtl/lh_rr_arbiter.sv
// Combinational N-way round-robin pick: first set request at or above ptr,
// wrapping, as a one-hot grant plus its index.
module lh_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  int   c;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int i = 0; i < N; i++) begin
      c = int'(ptr) + i;
      if (c >= N) c = c - N;
      if (!found && req[IW'(c)]) begin
        found         = 1'b1;
        idx           = IW'(c);
        grant[IW'(c)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lh_hash_arbiter.sv
// Shares one light_hash core between N_REQ byte-stream requesters: frames each
// granted message with 0xFF/0x00, paces bytes, and returns digest plus status.
// Handshake: a requester byte transfers on a cycle where req_valid[i] and
// req_ready[i] are both high; req_last is only meaningful on such a cycle.
module lh_hash_arbiter
  import lh_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int MAX_MSG_LEN    = 32,
  parameter int BYTE_GAP       = 2,
  parameter int DIGEST_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_byte,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [63:0]          rsp_digest,
  output logic [1:0]           rsp_status,
  output logic [7:0]           core_byte,
  output logic                 core_valid,
  input  logic [63:0]          core_digest,
  input  logic                 core_digest_ready,
  input  logic                 core_err,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output lh_arb_state_t        dbg_state
);

  localparam int IW = $clog2(N_REQ);
  localparam int GW = $clog2(BYTE_GAP + 1);
  localparam int LW = $clog2(MAX_MSG_LEN + 1);
  localparam int TW = $clog2(DIGEST_TIMEOUT + 1);

  lh_arb_state_t state;
  logic [GW-1:0] gap_cnt;
  logic [LW-1:0] len;
  logic [TW-1:0] tmo_cnt;
  lh_status_t    status_q;
  logic [63:0]   digest_q;
  logic [IW-1:0] rr_ptr;

  logic [N_REQ-1:0] arb_grant;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;
  logic [IW-1:0]    gidx;
  logic [7:0]       cur_byte;
  logic             cur_last;
  logic             ready_now;
  logic             accept;

  lh_rr_arbiter #(.N(N_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign arb_any   = |arb_grant;
  assign gidx      = grant_id[IW-1:0];
  assign cur_byte  = req_byte[{gidx, 3'b000} +: 8];
  assign cur_last  = req_last[gidx];
  assign ready_now = ((state == S_DATA) && (gap_cnt == '0)) || (state == S_FLUSH);
  assign accept    = ready_now && req_valid[gidx];

  assign req_ready  = ready_now ? (N_REQ'(1) << gidx) : '0;
  assign rsp_valid  = (state == S_RESP) ? (N_REQ'(1) << gidx) : '0;
  assign rsp_digest = (state == S_RESP) ? digest_q : '0;
  assign rsp_status = (state == S_RESP) ? status_q : STAT_OK;
  assign busy       = (state != S_IDLE);
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      gap_cnt    <= '0;
      len        <= '0;
      tmo_cnt    <= '0;
      status_q   <= STAT_OK;
      digest_q   <= '0;
      rr_ptr     <= '0;
      grant_id   <= '0;
      core_byte  <= TAIL_BYTE;
      core_valid <= 1'b0;
    end else begin
      core_valid <= 1'b0;
      if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
      case (state)
        S_IDLE: begin
          if (arb_any) begin
            grant_id   <= 3'(arb_idx);
            status_q   <= STAT_OK;
            digest_q   <= '0;
            len        <= '0;
            core_byte  <= HEAD_BYTE;
            core_valid <= 1'b1;
            gap_cnt    <= GW'(BYTE_GAP);
            state      <= S_HEAD;
          end
        end
        S_HEAD: begin
          if (gap_cnt == GW'(1)) state <= S_DATA;
        end
        S_DATA: begin
          // A core error wins over a byte accepted in the same cycle.
          if (core_err) begin
            status_q <= STAT_INVALID_BYTE;
            state    <= (accept && cur_last) ? S_RESP : S_FLUSH;
          end else if (accept) begin
            if (!is_payload_byte(cur_byte)) begin
              status_q <= STAT_INVALID_BYTE;
              state    <= cur_last ? S_RESP : S_FLUSH;
            end else if (len == LW'(MAX_MSG_LEN)) begin
              status_q <= STAT_TOO_LONG;
              state    <= cur_last ? S_RESP : S_FLUSH;
            end else begin
              core_byte  <= cur_byte;
              core_valid <= 1'b1;
              len        <= len + 1'b1;
              gap_cnt    <= GW'(BYTE_GAP);
              if (cur_last) state <= S_TAIL;
            end
          end
        end
        S_TAIL: begin
          if (gap_cnt == '0) begin
            core_byte  <= TAIL_BYTE;
            core_valid <= 1'b1;
            tmo_cnt    <= '0;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (core_digest_ready) begin
            digest_q <= core_digest;
            status_q <= STAT_OK;
            state    <= S_RESP;
          end else if (tmo_cnt == TW'(DIGEST_TIMEOUT - 1)) begin
            status_q <= STAT_TIMEOUT;
            state    <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_FLUSH: begin
          if (accept && cur_last) state <= S_RESP;
        end
        S_RESP: begin
          rr_ptr <= (gidx == IW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lh_hash_arbiter.sv
// Randomized self-checking bench for lh_hash_arbiter with a light_hash core stub
// and a message-level reference model.
module tb_lh_hash_arbiter;
  import lh_pkg::*;

  localparam int N   = 4;
  localparam int MAX = 32;
  localparam int G   = 2;
  localparam int DT  = 64;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [8*N-1:0]  req_byte;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [63:0]     rsp_digest;
  logic [1:0]      rsp_status;
  logic [7:0]      core_byte;
  logic            core_valid;
  logic [63:0]     core_digest;
  logic            core_digest_ready;
  logic            core_err;
  logic            busy;
  logic [2:0]      grant_id;
  lh_arb_state_t   dbg_state;

  logic            tb_valid [N];
  logic [7:0]      tb_byte  [N];
  logic            tb_last  [N];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int model_ptr = 0;

  logic [7:0]  exp_q[$];
  logic [68:0] exp_rsp_q[$];
  int          exp_gnt_q[$];

  logic        stub_respond = 1'b1;
  logic [63:0] stub_digest  = '0;
  int          stub_err_at  = 0;
  int          stub_pay_cnt = 0;

  lh_hash_arbiter #(.N_REQ(N), .MAX_MSG_LEN(MAX), .BYTE_GAP(G), .DIGEST_TIMEOUT(DT)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_byte          (req_byte),
    .req_last          (req_last),
    .req_ready         (req_ready),
    .rsp_valid         (rsp_valid),
    .rsp_digest        (rsp_digest),
    .rsp_status        (rsp_status),
    .core_byte         (core_byte),
    .core_valid        (core_valid),
    .core_digest       (core_digest),
    .core_digest_ready (core_digest_ready),
    .core_err          (core_err),
    .busy              (busy),
    .grant_id          (grant_id),
    .dbg_state         (dbg_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always_comb begin
    req_valid = '0;
    req_byte  = '0;
    req_last  = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = tb_valid[i];
      req_byte[8*i +: 8] = tb_byte[i];
      req_last[i]        = tb_last[i];
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model
  function automatic bit is_valid(input logic [7:0] b);
    return b inside {[8'h20:8'h7E], [8'hA1:8'hFE]};
  endfunction

  function automatic int rr_pick(input logic [7:0] mask, input int ptr);
    for (int i = 0; i < N; i++)
      if (mask[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  task automatic expect_msg(input int id, input logic [7:0] msg[$], input bit respond,
                            input logic [63:0] dig, input int err_at);
    logic [1:0] st;
    st = 2'd0;
    exp_q.push_back(8'hFF);
    for (int i = 0; i < msg.size(); i++) begin
      if (!is_valid(msg[i])) begin st = 2'd1; break; end
      if (i == MAX) begin st = 2'd2; break; end
      exp_q.push_back(msg[i]);
      if (err_at != 0 && i + 1 == err_at) begin st = 2'd1; break; end
    end
    if (st == 2'd0) begin
      exp_q.push_back(8'h00);
      if (!respond) st = 2'd3;
    end
    exp_rsp_q.push_back({3'(id), st, (st == 2'd0) ? dig : 64'd0});
    exp_gnt_q.push_back(id);
    model_ptr = (id + 1) % N;
  endtask

  // Core stub: digest 3 cycles after the tail pulse, optional error after a payload pulse
  initial begin
    core_digest       = '0;
    core_digest_ready = 1'b0;
    core_err          = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && core_valid) begin
        if (core_byte == 8'hFF) begin
          stub_pay_cnt = 0;
        end else if (core_byte == 8'h00) begin
          if (stub_respond) begin
            repeat (3) @(posedge clk);
            #1;
            core_digest       = stub_digest;
            core_digest_ready = 1'b1;
            @(posedge clk);
            #1;
            core_digest_ready = 1'b0;
          end
        end else begin
          stub_pay_cnt++;
          if (stub_pay_cnt == stub_err_at) begin
            core_err = 1'b1;
            @(posedge clk);
            #1;
            core_err = 1'b0;
          end
        end
      end
    end
  end

  // Scoreboard / monitor
  int  last_pulse = 0;
  int  tail_cyc   = 0;
  bit  rsp_prev   = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_prev) check_eq("busy_after_rsp", busy, 1'b0);
      rsp_prev = |rsp_valid;
      if (core_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("core_unexpected", exp_q.size(), 1);
        end else begin
          check_eq("core_byte", core_byte, exp_q.pop_front());
        end
        if (core_byte == 8'hFF) begin
          if (exp_gnt_q.size() == 0) check_eq("grant_unexpected", exp_gnt_q.size(), 1);
          else check_eq("grant_id", grant_id, exp_gnt_q.pop_front());
        end else begin
          check_eq("pulse_spacing", cyc - last_pulse, G + 1);
        end
        if (core_byte == 8'h00) tail_cyc = cyc;
        last_pulse = cyc;
      end
      if (|rsp_valid) begin
        int          rid;
        logic [68:0] e;
        rid = 0;
        for (int i = 0; i < N; i++) if (rsp_valid[i]) rid = i;
        check_eq("rsp_onehot", $countones(rsp_valid), 1);
        if (exp_rsp_q.size() == 0) begin
          check_eq("rsp_unexpected", exp_rsp_q.size(), 1);
        end else begin
          e = exp_rsp_q.pop_front();
          check_eq("rsp", {3'(rid), rsp_status, rsp_digest}, e);
          if (e[65:64] == 2'd3) check_eq("timeout_latency", cyc - tail_cyc, DT);
        end
      end
    end
  end

  // Driver tasks
  task automatic send_msg(input int id, input logic [7:0] msg[$]);
    bit accepted;
    for (int k = 0; k < msg.size(); k++) begin
      tb_byte[id]  = msg[k];
      tb_last[id]  = (k == msg.size() - 1);
      tb_valid[id] = 1'b1;
      accepted = 1'b0;
      for (int t = 0; t < 3000 && !accepted; t++) begin
        @(negedge clk);
        if (req_ready[id]) accepted = 1'b1;
        @(posedge clk);
        #1;
      end
      if (!accepted) begin
        check_eq("driver_accept", accepted, 1'b1);
        break;
      end
    end
    tb_valid[id] = 1'b0;
    tb_last[id]  = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (exp_rsp_q.size() == 0 && !busy) break;
    end
    check_eq("drain_rsp", exp_rsp_q.size(), 0);
    check_eq("drain_core", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input int id, input logic [7:0] msg[$], input bit respond,
                         input logic [63:0] dig, input int err_at);
    stub_respond = respond;
    stub_digest  = dig;
    stub_err_at  = err_at;
    expect_msg(id, msg, respond, dig, err_at);
    send_msg(id, msg);
    wait_idle();
  endtask

  task automatic run_pair(input int a, input logic [7:0] ma[$], input int b, input logic [7:0] mb[$],
                          input logic [63:0] dig);
    logic [7:0] mask;
    mask = '0;
    mask[a] = 1'b1;
    mask[b] = 1'b1;
    stub_respond = 1'b1;
    stub_digest  = dig;
    stub_err_at  = 0;
    if (rr_pick(mask, model_ptr) == a) begin
      expect_msg(a, ma, 1'b1, dig, 0);
      expect_msg(b, mb, 1'b1, dig, 0);
    end else begin
      expect_msg(b, mb, 1'b1, dig, 0);
      expect_msg(a, ma, 1'b1, dig, 0);
    end
    fork
      send_msg(a, ma);
      send_msg(b, mb);
    join
    wait_idle();
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_core_byte"},  core_byte, 8'h00);
    check_eq({tag, "_core_valid"}, core_valid, 1'b0);
    check_eq({tag, "_req_ready"},  req_ready, '0);
    check_eq({tag, "_rsp_valid"},  rsp_valid, '0);
    check_eq({tag, "_rsp_digest"}, rsp_digest, 64'd0);
    check_eq({tag, "_rsp_status"}, rsp_status, 2'd0);
    check_eq({tag, "_busy"},       busy, 1'b0);
    check_eq({tag, "_grant_id"},   grant_id, 3'd0);
    check_eq({tag, "_state"},      dbg_state, S_IDLE);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  logic [7:0] m[$];
  logic [7:0] m2[$];
  logic [7:0] bad_tab[6];

  initial begin
    bad_tab = '{8'h00, 8'hFF, 8'h07, 8'h1F, 8'h7F, 8'hA0};
    for (int i = 0; i < N; i++) begin
      tb_valid[i] = 1'b0;
      tb_byte[i]  = 8'h00;
      tb_last[i]  = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Round-robin from pointer 0: 1 before 2, then 3 before 1
    m = '{8'h61, 8'h62};
    m2 = '{8'h71, 8'h72, 8'h73};
    run_pair(1, m, 2, m2, 64'hAAAA_0000_1111_2222);
    run_pair(1, m, 3, m2, 64'h3333_4444_5555_6666);

    m = '{8'h61, 8'h62, 8'h63};
    run_one(0, m, 1'b1, 64'h0123456789ABCDEF, 0);

    m = '{8'h41, 8'h07, 8'h42};
    run_one(0, m, 1'b1, 64'h0123456789ABCDEF, 0);

    m = {};
    for (int i = 0; i < MAX + 1; i++) m.push_back(8'h61);
    run_one(0, m, 1'b1, 64'h0123456789ABCDEF, 0);

    m = '{8'h61, 8'h62, 8'h63};
    run_one(0, m, 1'b0, 64'h0123456789ABCDEF, 0);

    m = '{8'h30, 8'h31, 8'hB0, 8'h32, 8'h33};
    run_one(2, m, 1'b1, 64'hDEAD_BEEF_0000_0001, 2);

    for (int r = 0; r < 25; r++) begin
      int id;
      int len;
      int err_at;
      id  = $urandom_range(0, N - 1);
      len = $urandom_range(1, MAX + 4);
      m = {};
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 29) == 0) m.push_back(bad_tab[$urandom_range(0, 5)]);
        else if ($urandom_range(0, 1) == 1) m.push_back(8'($urandom_range(8'h20, 8'h7E)));
        else m.push_back(8'($urandom_range(8'hA1, 8'hFE)));
      end
      err_at = 0;
      if ($urandom_range(0, 7) == 0) err_at = $urandom_range(1, 3);
      if (err_at >= len) err_at = 0;
      run_one(id, m, ($urandom_range(0, 5) != 0), {$urandom, $urandom}, err_at);
    end

    // Leave the pointer at 2, then reset mid-message
    m = '{8'h45};
    run_one(1, m, 1'b1, 64'h1, 0);

    begin
      bit found;
      stub_respond = 1'b1;
      stub_err_at  = 0;
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h61);
      exp_q.push_back(8'h62);
      exp_gnt_q.push_back(0);
      tb_byte[0]  = 8'h61;
      tb_last[0]  = 1'b0;
      tb_valid[0] = 1'b1;
      found = 1'b0;
      for (int t = 0; t < 200 && !found; t++) begin
        @(negedge clk);
        if (core_valid && core_byte == 8'h61) found = 1'b1;
      end
      tb_byte[0] = 8'h62;
      for (int t = 0; t < 200 && found; t++) begin
        @(negedge clk);
        if (core_valid && core_byte == 8'h62) break;
      end
      check_eq("reset_reach_data", found, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("async_reset");
      tb_valid[0] = 1'b0;
      model_ptr = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq("reset_core_q", exp_q.size(), 0);
      check_eq("reset_gnt_q", exp_gnt_q.size(), 0);
    end

    m = '{8'h51};
    m2 = '{8'h52, 8'h53};
    run_pair(1, m, 3, m2, 64'hFEED_FACE_CAFE_F00D);

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
